// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch stage, the IF/ID register and the decode/hazard consumers.
interface if_id_stage_if;
  logic [15:0] PC_in_IF;
  logic [15:0] instr_IF;
  logic        MemRead_EX;
  logic [2:0]  rtaddr_EX;
  logic        PCSrc_EX;
  logic [15:0] PC_out_ID;
  logic [15:0] instr_ID;
  logic        valid_ID;
  logic [2:0]  opcode_ID;
  logic [2:0]  rsaddr_ID;
  logic [2:0]  rtaddr_ID;
  logic [2:0]  rdaddr_ID;
  logic [3:0]  funct_ID;
  logic [15:0] ZeroFilled_ID;
  logic [15:0] SignExtend_ID;
  logic        PCWrite;
  logic        IDEXflush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output PC_in_IF, instr_IF, MemRead_EX, rtaddr_EX, PCSrc_EX,
    input  PC_out_ID, instr_ID, valid_ID, opcode_ID, rsaddr_ID, rtaddr_ID,
           rdaddr_ID, funct_ID, ZeroFilled_ID, SignExtend_ID, PCWrite,
           IDEXflush, stall_cnt, flush_cnt
  );

  modport slave (
    input  PC_in_IF, instr_IF, MemRead_EX, rtaddr_EX, PCSrc_EX,
    output PC_out_ID, instr_ID, valid_ID, opcode_ID, rsaddr_ID, rtaddr_ID,
           rdaddr_ID, funct_ID, ZeroFilled_ID, SignExtend_ID, PCWrite,
           IDEXflush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field decode, load-use hazard detection,
// PC/ID-EX control generation and saturating stall/flush event counters.
module if_id_stage (
  input  logic          clk_i,
  input  logic          rst_n,
  if_id_stage_if.slave  bus
);
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;

  // r0 is hardwired zero, so a load targeting it never creates a hazard
  always_comb begin
    load_use = bus.MemRead_EX && valid_q && (bus.rtaddr_EX != 3'd0) &&
               ((bus.rtaddr_EX == instr_q[12:10]) || (bus.rtaddr_EX == instr_q[9:7]));
  end

  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.PCSrc_EX) begin
      pc_d        = '0;
      instr_d     = '0;
      valid_d     = 1'b0;
      flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + 16'd1;
    end else if (load_use) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 16'd1;
    end else begin
      pc_d    = bus.PC_in_IF;
      instr_d = bus.instr_IF;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PC_out_ID     = pc_q;
  assign bus.instr_ID      = instr_q;
  assign bus.valid_ID      = valid_q;
  assign bus.opcode_ID     = instr_q[15:13];
  assign bus.rsaddr_ID     = instr_q[12:10];
  assign bus.rtaddr_ID     = instr_q[9:7];
  assign bus.rdaddr_ID     = instr_q[6:4];
  assign bus.funct_ID      = instr_q[3:0];
  assign bus.ZeroFilled_ID = {9'b0, instr_q[6:0]};
  assign bus.SignExtend_ID = {{9{instr_q[6]}}, instr_q[6:0]};
  assign bus.PCWrite       = bus.PCSrc_EX || !load_use;
  assign bus.IDEXflush     = bus.PCSrc_EX || load_use;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: decode, load-use stall, r0 exemption,
// branch flush priority, counter saturation and asynchronous reset.
module tb_if_id_stage;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  if_id_stage_if bus();

  if_id_stage dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pc"},    32'(bus.PC_out_ID), 32'h0);
    check({tag, ".instr"}, 32'(bus.instr_ID),  32'h0);
    check({tag, ".valid"}, 32'(bus.valid_ID),  32'h0);
    check({tag, ".stall"}, 32'(bus.stall_cnt), 32'h0);
    check({tag, ".flush"}, 32'(bus.flush_cnt), 32'h0);
  endtask

  initial begin
    bus.PC_in_IF   = 16'h0;
    bus.instr_IF   = 16'h0;
    bus.MemRead_EX = 1'b0;
    bus.rtaddr_EX  = 3'd0;
    bus.PCSrc_EX   = 1'b0;
    #3;
    check_all_zero("rst");
    check("rst.sext",  32'(bus.SignExtend_ID), 32'h0);
    check("rst.op",    32'(bus.opcode_ID),     32'h0);
    check("rst.pcw",   32'(bus.PCWrite),       32'h1);
    check("rst.flush", 32'(bus.IDEXflush),     32'h0);
    #4 rst_n = 1'b1;

    // Normal advance and field decode
    bus.instr_IF = 16'h2A53;
    bus.PC_in_IF = 16'h0010;
    tick();
    check("dec.op",    32'(bus.opcode_ID),     32'h1);
    check("dec.rs",    32'(bus.rsaddr_ID),     32'h2);
    check("dec.rt",    32'(bus.rtaddr_ID),     32'h4);
    check("dec.rd",    32'(bus.rdaddr_ID),     32'h5);
    check("dec.fn",    32'(bus.funct_ID),      32'h3);
    check("dec.zf",    32'(bus.ZeroFilled_ID), 32'h0053);
    check("dec.se",    32'(bus.SignExtend_ID), 32'hFFD3);
    check("dec.pc",    32'(bus.PC_out_ID),     32'h0010);
    check("dec.valid", 32'(bus.valid_ID),      32'h1);

    // Load-use on rt = 4
    bus.instr_IF   = 16'h1234;
    bus.PC_in_IF   = 16'h0012;
    bus.MemRead_EX = 1'b1;
    bus.rtaddr_EX  = 3'd4;
    #1;
    check("lu.pcw",   32'(bus.PCWrite),   32'h0);
    check("lu.flush", 32'(bus.IDEXflush), 32'h1);
    tick();
    check("lu.hold",  32'(bus.instr_ID),  32'h2A53);
    check("lu.pchold",32'(bus.PC_out_ID), 32'h0010);
    check("lu.cnt",   32'(bus.stall_cnt), 32'h1);
    bus.MemRead_EX = 1'b0;
    #1;
    check("lu.rel.pcw", 32'(bus.PCWrite), 32'h1);
    tick();
    check("lu.next",   32'(bus.instr_ID),  32'h1234);
    check("lu.nextpc", 32'(bus.PC_out_ID), 32'h0012);
    check("lu.cnt2",   32'(bus.stall_cnt), 32'h1);

    // r0 exemption and rt/rs matching with rs=0, rt=1
    bus.instr_IF = 16'h0085;
    bus.PC_in_IF = 16'h0020;
    tick();
    bus.MemRead_EX = 1'b1;
    bus.rtaddr_EX  = 3'd0;
    #1;
    check("r0.pcw",   32'(bus.PCWrite),   32'h1);
    check("r0.flush", 32'(bus.IDEXflush), 32'h0);
    bus.rtaddr_EX = 3'd2;
    #1;
    check("nomatch.pcw", 32'(bus.PCWrite), 32'h1);
    bus.rtaddr_EX = 3'd1;
    #1;
    check("rtmatch.pcw", 32'(bus.PCWrite), 32'h0);

    // Branch flush wins over concurrent load-use
    bus.PCSrc_EX = 1'b1;
    #1;
    check("br.pcw",   32'(bus.PCWrite),   32'h1);
    check("br.flush", 32'(bus.IDEXflush), 32'h1);
    tick();
    check("br.instr", 32'(bus.instr_ID),  32'h0);
    check("br.valid", 32'(bus.valid_ID),  32'h0);
    check("br.pc",    32'(bus.PC_out_ID), 32'h0);
    check("br.fcnt",  32'(bus.flush_cnt), 32'h1);
    check("br.scnt",  32'(bus.stall_cnt), 32'h1);
    tick();
    tick();
    check("br.fcnt3", 32'(bus.flush_cnt), 32'h3);
    bus.PCSrc_EX = 1'b0;
    #1;
    check("bubble.pcw", 32'(bus.PCWrite), 32'h1);

    // Asynchronous reset mid-stall
    bus.MemRead_EX = 1'b0;
    bus.instr_IF   = 16'h2A53;
    bus.PC_in_IF   = 16'h0010;
    tick();
    bus.MemRead_EX = 1'b1;
    bus.rtaddr_EX  = 3'd4;
    tick();
    check("ar.pre", 32'(bus.stall_cnt), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("ar");
    bus.MemRead_EX = 1'b0;
    bus.instr_IF   = 16'h5555;
    bus.PC_in_IF   = 16'h0030;
    #1 rst_n = 1'b1;
    tick();
    check("ar.instr", 32'(bus.instr_ID),  32'h5555);
    check("ar.pc",    32'(bus.PC_out_ID), 32'h0030);
    check("ar.valid", 32'(bus.valid_ID),  32'h1);

    // Stall counter saturation
    bus.instr_IF = 16'h2A53;
    tick();
    bus.MemRead_EX = 1'b1;
    bus.rtaddr_EX  = 3'd4;
    repeat (65534) tick();
    check("sat.pre", 32'(bus.stall_cnt), 32'hFFFE);
    repeat (6) tick();
    check("sat.cnt",   32'(bus.stall_cnt), 32'hFFFF);
    check("sat.instr", 32'(bus.instr_ID),  32'h2A53);
    check("sat.fcnt",  32'(bus.flush_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
